vfifo_sc_ctrl: RTL and testbench

VFIFO_SC_CTRL -- requirements
Module: vfifo_sc_ctrl

---
 rtl/vfifo_sc_ctrl.sv | 108 ++++++++++
 tb/tb_vfifo_sc_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vfifo_sc_ctrl.sv
// rtl/vfifo_sc_ctrl.sv - single-clock FIFO controller for an external dual-port RAM (optional error flags: VFIFO_SC_CTRL_ERR_FLAGS_EN)
module vfifo_sc_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_acc, rd_acc;

  // Fill level and flags come only from registered pointers.
  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    empty = (count == '0);
    full  = (count == DEPTH_C);
  end

  // Access acceptance and RAM port drive; dropped accesses never reach the RAM.
  always_comb begin
    wr_acc    = wr_en & ~full;
    rd_acc    = rd_en & ~empty;
    ram_we_a  = wr_acc;
    ram_adr_a = wr_ptr_q[ADDR_WIDTH-1:0];
    ram_d_a   = wr_data;
    ram_adr_b = rd_ptr_q[ADDR_WIDTH-1:0];
    rd_data   = ram_q_b;
    rd_valid  = rd_valid_q;
  end

  // Next-state for pointers and the read strobe (RAM read latency is one cycle).
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
    rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
    rd_valid_d = rd_acc;
  end

  // Pointer and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef VFIFO_SC_CTRL_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; a clear in the same cycle as a new error wins.
  always_comb begin
    overflow_d  = overflow_q | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_clr_err;

  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_vfifo_sc_ctrl.sv
// tb/tb_vfifo_sc_ctrl.sv - self-checking bench for vfifo_sc_ctrl with a queue-based reference model
module tb_vfifo_sc_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef VFIFO_SC_CTRL_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic [AW:0]   count;
  logic [DW-1:0] ram_d_a;
  logic [AW-1:0] ram_adr_a;
  logic          ram_we_a;
  logic [AW-1:0] ram_adr_b;
  logic [DW-1:0] ram_q_b;
  logic          overflow;
  logic          underflow;
  logic          clr_err = 1'b0;

  always #5 clk = ~clk;

  vfifo_sc_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .count(count), .ram_d_a(ram_d_a), .ram_adr_a(ram_adr_a), .ram_we_a(ram_we_a),
    .ram_adr_b(ram_adr_b), .ram_q_b(ram_q_b), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  // Dual-port RAM with registered read address
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] adr_b_q;
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
    adr_b_q <= ram_adr_b;
  end
  assign ram_q_b = mem[adr_b_q];

  // Reference model
  logic [DW-1:0] mq[$];
  bit            exp_rv;
  logic [DW-1:0] exp_rd;
  bit            exp_ovf, exp_unf;
  int            wr_total, rd_total;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_rv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    wr_total = 0;
    rd_total = 0;
  endtask

  task automatic check_state();
    chk("count", 64'(count), 64'(mq.size()));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
    if (exp_rv) chk("rd_data", 64'(rd_data), 64'(exp_rd));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    chk("underflow", 64'(underflow), 64'(exp_unf));
  endtask

  // One clock cycle: drive, check RAM port, clock, update model, check state.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    int sz;
    bit wa, ra;
    sz = mq.size();
    wa = w && (sz < DEPTH);
    ra = r && (sz > 0);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    #1;
    chk("ram_we_a", 64'(ram_we_a), 64'(wa));
    if (wa) begin
      chk("ram_adr_a", 64'(ram_adr_a), 64'(wr_total % DEPTH));
      chk("ram_d_a", 64'(ram_d_a), 64'(d));
    end
    chk("ram_adr_b", 64'(ram_adr_b), 64'(rd_total % DEPTH));
    @(posedge clk);
    exp_rv = ra;
    if (ra) begin
      exp_rd = mq.pop_front();
      rd_total++;
    end
    if (wa) begin
      mq.push_back(d);
      wr_total++;
    end
    if (ERR_EN) begin
      if (c) begin
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
      end else begin
        if (w && !wa) exp_ovf = 1'b1;
        if (r && sz == 0) exp_unf = 1'b1;
      end
    end
    @(negedge clk);
    check_state();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  typedef struct {
    bit            w;
    logic [DW-1:0] d;
    bit            r;
    int            e_count;
    bit            e_empty;
    bit            e_rv;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{w:1'b0, d:32'h0,        r:1'b0, e_count:0, e_empty:1'b1, e_rv:1'b0, e_rd:32'h0};
    tbl[1] = '{w:1'b1, d:32'hA5A5A5A5, r:1'b0, e_count:1, e_empty:1'b0, e_rv:1'b0, e_rd:32'h0};
    tbl[2] = '{w:1'b0, d:32'h0,        r:1'b1, e_count:0, e_empty:1'b1, e_rv:1'b1, e_rd:32'hA5A5A5A5};
    tbl[3] = '{w:1'b1, d:32'h12345678, r:1'b1, e_count:1, e_empty:1'b0, e_rv:1'b0, e_rd:32'h0};
    tbl[4] = '{w:1'b1, d:32'h0BADF00D, r:1'b1, e_count:1, e_empty:1'b0, e_rv:1'b1, e_rd:32'h12345678};

    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_state();
    chk("reset_we", 64'(ram_we_a), 64'd0);
    rst = 1'b0;

    // Directed table: first-word latency and simultaneous access
    for (int i = 0; i < 5; i++) begin
      cyc(tbl[i].w, tbl[i].d, tbl[i].r, 1'b0);
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_count));
      chk($sformatf("tbl%0d_empty", i), 64'(empty), 64'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_rv", i), 64'(rd_valid), 64'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_rd", i), 64'(rd_data), 64'(tbl[i].e_rd));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Fill to full, then a dropped write
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'(DEPTH));
    cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("drop_count", 64'(count), 64'(DEPTH));
    chk("drop_overflow", 64'(overflow), 64'(ERR_EN));

    // Full with simultaneous read and write: read only
    cyc(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
    chk("full_rw_count", 64'(count), 64'(DEPTH - 1));

    // Drain, then underflow and clear
    while (mq.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("underflow_rv", 64'(rd_valid), 64'd0);
    chk("underflow_flag", 64'(underflow), 64'(ERR_EN));
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_underflow", 64'(underflow), 64'd0);
    chk("clr_overflow", 64'(overflow), 64'd0);

    // Streaming at constant count=4 across pointer wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h1000 + i, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      cyc(1'b1, 32'h1004 + i, 1'b1, 1'b0);
      chk("stream_count", 64'(count), 64'd4);
      chk("stream_order", 64'(rd_data), 64'(32'h1000 + i));
    end
    while (mq.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream at count=10 with rd_valid high
    for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b1, $urandom, 1'b1, 1'b0);
    chk("pre_rst_rv", 64'(rd_valid), 64'd1);
    chk("pre_rst_count", 64'(count), 64'd10);
    #2;
    rst = 1'b1;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_empty", 64'(empty), 64'd1);
    chk("async_rv", 64'(rd_valid), 64'd0);
    chk("async_we", 64'(ram_we_a), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_state();

    // Randomised traffic with shifting write/read bias
    for (int i = 0; i < 2400; i++) begin
      int pw, pr;
      pw = ((i / 300) % 2 == 0) ? 75 : 30;
      pr = 100 - pw;
      cyc($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pr,
          $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
